// File: rtl/vtc_pkg.sv
// Shared definitions for the video timing controller: axis state encoding,
// coordinate width and the TMDS channel-0 control symbol layout.
package vtc_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } axis_state_t;

    // Channel-0 control symbol, ordered {vsync, hsync}.
    typedef struct packed {
        logic vsync;
        logic hsync;
    } ctrl_t;

    function automatic axis_state_t next_segment(input axis_state_t s);
        case (s)
            ACTIVE:  return FRONT;
            FRONT:   return SYNC;
            SYNC:    return BACK;
            default: return ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/vtc_axis.sv
// One raster axis: ACTIVE -> FRONT -> SYNC -> BACK sequencer with a segment
// counter that advances on step and flags the BACK -> ACTIVE wrap.
module vtc_axis
    import vtc_pkg::*;
#(
    parameter int L_ACTIVE = 640,
    parameter int L_FRONT  = 16,
    parameter int L_SYNC   = 96,
    parameter int L_BACK   = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    output axis_state_t        state,
    output logic [COORD_W-1:0] count,
    output logic               wrap
);

    axis_state_t        state_d;
    logic [COORD_W-1:0] count_d;
    logic               seg_last;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        seg_last = 1'b0;
        case (state)
            ACTIVE: seg_last = (count == COORD_W'(L_ACTIVE - 1));
            FRONT:  seg_last = (count == COORD_W'(L_FRONT - 1));
            SYNC:   seg_last = (count == COORD_W'(L_SYNC - 1));
            BACK:   seg_last = (count == COORD_W'(L_BACK - 1));
            default: seg_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state;
        count_d = count;
        if (step) begin
            if (seg_last) begin
                state_d = next_segment(state);
                count_d = '0;
            end else begin
                count_d = count + COORD_W'(1);
            end
        end
    end

    assign wrap = step && seg_last && (state == BACK);

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACTIVE;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer for the HDMI TMDS encoders: data enable, sync controls and
// pixel coordinates. Define VTC_LOOKAHEAD_EN to make pix_req/x/y lead o_de by one cycle.
module video_timing_ctrl
    import vtc_pkg::*;
#(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    output logic               o_de,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic [1:0]         o_ctrl,
    output logic               o_pix_req,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_line_start,
    output logic               o_frame_start
);

    axis_state_t        h_state, v_state;
    logic [COORD_W-1:0] h_count, v_count;
    logic               h_wrap, v_wrap_unused;
    logic               cur_active;
    ctrl_t              ctrl_q;

    vtc_axis #(
        .L_ACTIVE(H_ACTIVE), .L_FRONT(H_FP), .L_SYNC(H_SYNC), .L_BACK(H_BP)
    ) u_h_axis (
        .clk(i_clk), .rst(i_rst), .step(i_en),
        .state(h_state), .count(h_count), .wrap(h_wrap)
    );

    // The vertical axis steps once per line; its own wrap has no consumer.
    vtc_axis #(
        .L_ACTIVE(V_ACTIVE), .L_FRONT(V_FP), .L_SYNC(V_SYNC), .L_BACK(V_BP)
    ) u_v_axis (
        .clk(i_clk), .rst(i_rst), .step(h_wrap),
        .state(v_state), .count(v_count), .wrap(v_wrap_unused)
    );

    assign cur_active = (h_state == ACTIVE) && (v_state == ACTIVE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_de          <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            ctrl_q        <= '{vsync: ~V_POL, hsync: ~H_POL};
        end else if (i_en) begin
            o_de          <= cur_active;
            o_line_start  <= cur_active && (h_count == '0);
            o_frame_start <= cur_active && (h_count == '0) && (v_count == '0);
            ctrl_q.hsync  <= (h_state == SYNC) ? H_POL : ~H_POL;
            ctrl_q.vsync  <= (v_state == SYNC) ? V_POL : ~V_POL;
        end
    end

    assign o_hsync = ctrl_q.hsync;
    assign o_vsync = ctrl_q.vsync;
    assign o_ctrl  = ctrl_q;

`ifdef VTC_LOOKAHEAD_EN
    // The axis registers already hold the position the next o_de cycle will report,
    // so the request is decoded straight from them; started blanks it until the first step.
    logic started;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            started <= 1'b0;
        else if (i_en)
            started <= 1'b1;
    end

    assign o_pix_req = started && cur_active;
    assign o_x       = o_pix_req ? h_count : '0;
    assign o_y       = o_pix_req ? v_count : '0;
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pix_req <= 1'b0;
            o_x       <= '0;
            o_y       <= '0;
        end else if (i_en) begin
            o_pix_req <= cur_active;
            o_x       <= cur_active ? h_count : '0;
            o_y       <= cur_active ? v_count : '0;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl on a tiny 8x6 raster; honours VTC_LOOKAHEAD_EN.
module tb_video_timing_ctrl;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        o_de, o_hsync, o_vsync, o_pix_req, o_line_start, o_frame_start;
    logic [1:0]  o_ctrl;
    logic [11:0] o_x, o_y;

    always #5 clk = ~clk;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_ctrl(o_ctrl),
        .o_pix_req(o_pix_req), .o_x(o_x), .o_y(o_y),
        .o_line_start(o_line_start), .o_frame_start(o_frame_start)
    );

    typedef struct packed {
        logic        de, hs, vs, pix;
        logic [11:0] x, y;
        logic        ls, fs;
    } exp_t;

    localparam exp_t RESET_EXP = '{de: 1'b0, hs: 1'b1, vs: 1'b1, pix: 1'b0,
                                   x: 12'd0, y: 12'd0, ls: 1'b0, fs: 1'b0};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // What the outputs report for raster position p (p = line*HT + column).
    function automatic exp_t raster_at(input int p);
        int   h;
        int   v;
        exp_t e;
        h     = p % HT;
        v     = p / HT;
        e.de  = (h < HA) && (v < VA);
        e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e.pix = e.de;
        e.x   = e.de ? 12'(h) : 12'd0;
        e.y   = e.de ? 12'(v) : 12'd0;
        e.ls  = e.de && (h == 0);
        e.fs  = (p == 0);
        return e;
    endfunction

    function automatic exp_t model_out(input int p);
        exp_t e;
        e = raster_at(p);
`ifdef VTC_LOOKAHEAD_EN
        begin
            exp_t n;
            n     = raster_at((p + 1) % FT);
            e.pix = n.pix;
            e.x   = n.x;
            e.y   = n.y;
        end
`endif
        return e;
    endfunction

    // Model: a raster position advancing once per enabled clock.
    exp_t exp_q;
    int   pos;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= RESET_EXP;
            pos   <= 0;
        end else if (en) begin
            exp_q <= model_out(pos);
            pos   <= (pos + 1) % FT;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("de",          o_de,          exp_q.de);
            check("hsync",       o_hsync,       exp_q.hs);
            check("vsync",       o_vsync,       exp_q.vs);
            check("ctrl",        o_ctrl,        {exp_q.vs, exp_q.hs});
            check("pix_req",     o_pix_req,     exp_q.pix);
            check("x",           o_x,           exp_q.x);
            check("y",           o_y,           exp_q.y);
            check("line_start",  o_line_start,  exp_q.ls);
            check("frame_start", o_frame_start, exp_q.fs);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_de"},   o_de,   0);
        check({tag, "_hs"},   o_hsync, 1);
        check({tag, "_vs"},   o_vsync, 1);
        check({tag, "_ctrl"}, o_ctrl, 3);
        check({tag, "_pix"},  o_pix_req, 0);
        check({tag, "_x"},    o_x,    0);
        check({tag, "_y"},    o_y,    0);
        check({tag, "_ls"},   o_line_start, 0);
        check({tag, "_fs"},   o_frame_start, 0);
    endtask

    task automatic wait_fs(output int edges);
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (!o_frame_start && edges < 200);
        if (!o_frame_start) check("fs_timeout", 0, 1);
    endtask

    initial begin
        int edges;
        int de_n, hs_n, vs_n, both_n, fs_n, first_hs, first_vs;
        logic       last_pix;
        logic [11:0] last_x, last_y;

        rst = 1'b1;
        en  = 1'b0;
        #1;
        check_reset_vals("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        wait_fs(edges);
        check("first_fs_edge", edges, 1);

        de_n = 0; hs_n = 0; vs_n = 0; both_n = 0; fs_n = 0; first_hs = -1; first_vs = -1;
        last_pix = 1'b0; last_x = '1; last_y = '1;
        for (int i = 0; i < FT; i++) begin
            de_n += int'(o_de);
            fs_n += int'(o_frame_start);
            if (!o_hsync) begin hs_n++; if (first_hs < 0) first_hs = i; end
            if (!o_vsync) begin vs_n++; if (first_vs < 0) first_vs = i; end
            if (o_ctrl == 2'b00) both_n++;
            if (i == FT - 1) begin last_pix = o_pix_req; last_x = o_x; last_y = o_y; end
            @(negedge clk);
        end
        check("fs_period_48", o_frame_start, 1);
        check("fs_once",      fs_n,     1);
        check("de_cycles",    de_n,     12);
        check("hsync_low",    hs_n,     12);
        check("hsync_offset", first_hs, 5);
        check("vsync_low",    vs_n,     8);
        check("vsync_start",  first_vs, 32);
        check("ctrl_00",      both_n,   2);
`ifdef VTC_LOOKAHEAD_EN
        check("pre_fs_pix", last_pix, 1);
        check("pre_fs_x",   last_x,   0);
        check("pre_fs_y",   last_y,   0);
`else
        check("pre_fs_pix", last_pix, 0);
        check("pre_fs_x",   last_x,   0);
        check("pre_fs_y",   last_y,   0);
`endif

        // Freeze for five cycles at x=2, y=1, then measure the stretched frame.
        edges = 0;
        while (!(o_x == 12'd2 && o_y == 12'd1) && edges < 100) begin
            @(negedge clk);
            edges++;
        end
`ifdef VTC_LOOKAHEAD_EN
        check("reach_x2y1", edges, 9);
`else
        check("reach_x2y1", edges, 10);
`endif
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            edges++;
        end
        check("frozen_x",  o_x,  2);
        check("frozen_y",  o_y,  1);
        check("frozen_de", o_de, 1);
        en = 1'b1;
        @(negedge clk);
        edges++;
        check("resume_x", o_x, 3);
        while (!o_frame_start && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check("gated_period", edges, 53);

        // Asynchronous reset in the middle of a line.
        edges = 0;
        while (!(o_x == 12'd1 && o_de) && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("reach_x1", int'(o_x == 12'd1 && o_de), 1);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_fs(edges);
        check("restart_fs_edge", edges, 1);
        check("restart_y", o_y, 0);
`ifdef VTC_LOOKAHEAD_EN
        check("restart_x", o_x, 1);
`else
        check("restart_x", o_x, 0);
`endif

        repeat (FT + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Raster sequencer that drives the three TMDS encoder channels of the HDMI output path. It generates the pixel-data-enable, the control symbols (hsync/vsync on channel 0, zero on channels 1/2) and the pixel coordinates for the frame source. It sits between the pixel clock domain root and the encoder, so the encoders never see a malformed blanking/active sequence.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)

Ports:
- i_clk  in  1  pixel clock; the block's only clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  run enable; 0 freezes the raster.
- o_de  out  1  pixel data enable to all encoders.
- o_hsync  out  1  hsync at the polarity set by H_POL.
- o_vsync  out  1  vsync at the polarity set by V_POL.
- o_ctrl  out  2  {o_vsync, o_hsync}, driven to the channel 0 encoder control input.
- o_pix_req  out  1  pixel fetch strobe to the frame source.
- o_x  out  12  active column of the requested pixel.
- o_y  out  12  active row of the requested pixel.
- o_line_start  out  1  one-cycle pulse at the first active pixel of each line.
- o_frame_start  out  1  one-cycle pulse at pixel (0,0).

## Operation
- Two cascaded axis FSMs, each with states ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Each FSM has its own segment counter. The state changes when the counter reaches segment length − 1.
  - The counter clears on every state change.
- Horizontal FSM advances every cycle in which i_en=1.
- Vertical FSM advances only on the horizontal BACK→ACTIVE transition (the line wrap).
- Totals are H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Every segment must be ≥1; zero-length segments are unsupported.
- Active region: o_de=1 when h_state=ACTIVE and v_state=ACTIVE.
- Sync outputs:
  - Hsync is asserted while h_state=SYNC, including during vertical blanking.
  - Vsync is asserted while v_state=SYNC. It changes only at the line wrap.
- Coordinates:
  - o_x is the horizontal counter while in active.
  - o_y is the vertical counter while in active.
  - Outside active, o_x and o_y hold 0.
- o_pix_req equals the active condition, before any lookahead shift.
- i_en=0 freezes FSMs, counters and all outputs at their current values. Pulses are not repeated while frozen. i_en=1 resumes from the exact cycle position.
- Reset values:
  - FSMs at h=ACTIVE and v=ACTIVE, counters 0.
  - o_de=0, o_pix_req=0, o_x=0, o_y=0, o_line_start=0, o_frame_start=0.
  - o_hsync=~H_POL, o_vsync=~V_POL, o_ctrl={~V_POL,~H_POL}.
- Reset mid-frame clears immediately (asynchronously). The first enabled cycle after reset release starts pixel (0,0).

## Timing
- All outputs are registered: they reflect FSM state one clock after the state is entered.
- First enabled cycle after reset: o_de=1, o_frame_start=1 and o_line_start=1 on the following edge.
- o_de stays high for exactly H_ACTIVE consecutive enabled cycles per active line. It stays low for H_TOTAL−H_ACTIVE cycles between lines.
- Frame period is exactly H_TOTAL×V_TOTAL enabled cycles.
- Encoder latency is 2 cycles; the encoder itself re-aligns de and ctrl. This block adds no compensation, so o_de, o_ctrl and coordinates are mutually aligned.
- Simultaneous horizontal and vertical wrap at end of frame: both FSMs update on the same edge. The next cycle is (0,0) with o_frame_start=1.

## Configuration
- VTC_LOOKAHEAD_EN defined:
  - o_pix_req, o_x and o_y lead o_de by one cycle, for registered/BRAM frame sources.
  - o_line_start and o_frame_start stay aligned to o_de.
  - The one-cycle lead applies across line and frame wrap: the request for (0,0) is issued in the last BACK cycle of the frame.
- Not defined: o_pix_req, o_x and o_y are aligned to o_de.

## Structure
- Shared package/header vtc_pkg:
  - axis state encoding (ACTIVE=2'd0, FRONT=2'd1, SYNC=2'd2, BACK=2'd3);
  - coordinate width constant (12);
  - the TMDS control symbol ordering {vsync, hsync}.
- Sub-module vtc_axis: one ACTIVE/FRONT/SYNC/BACK FSM with segment counter, step input and wrap output. It is instantiated twice (horizontal, vertical).

## Test plan
Use H=4/1/2/1 (H_TOTAL=8) and V=3/1/1/1 (V_TOTAL=6), polarities 0, unless stated.
- Reset release with i_en=1 → o_frame_start pulses cycle 1 and every 48 cycles after; o_de high 4 cycles of every 8 for 3 lines, then low 24 cycles.
- Hsync window → o_hsync=0 for exactly 2 cycles, starting 5 cycles after o_de rises, on every one of the 6 lines; o_ctrl[0] matches.
- Vsync window → o_vsync low for exactly 8 cycles, starting at line 4 start and aligned to the line wrap; o_ctrl=2'b00 during overlap with hsync.
- Enable gating: i_en=0 for 5 cycles at x=2, y=1 → all outputs frozen; after resume, o_x continues 2,3 and the frame period extends to 53 cycles.
- Async reset asserted mid-line (x=1) → all outputs at reset values with no clock edge; restart at (0,0).
- Build with VTC_LOOKAHEAD_EN → o_pix_req rises one cycle before o_de on every line; the request with o_x=0, o_y=0 occurs in the cycle before o_frame_start.
